// File: rtl/puzzle_state_queue.sv
// rtl/puzzle_state_queue.sv - BFS work queue over a 256 x 28-bit single-port puzzle-state memory
// Optional PUZZLE_QUEUE_BYPASS_EN loads a push straight into the output register when the queue is empty.
module puzzle_state_queue #(
  parameter int DATA_W = 28,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W+1:0] level,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   mem_count_q, mem_count_d;
  logic              pop_valid_q, pop_valid_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;

  logic drain, rd, wr, bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      mem_count_q <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      mem_count_q <= mem_count_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  // Reads win the single port; pushes wait while the output register can be refilled.
  always_comb begin
    drain = !pop_valid_q || pop_ready;
    rd    = (mem_count_q != '0) && drain;
`ifdef PUZZLE_QUEUE_BYPASS_EN
    bypass = (mem_count_q == '0) && drain && push_valid;
`else
    bypass = 1'b0;
`endif
    push_ready = ((mem_count_q != DEPTH_C) && !rd) || bypass;
    wr         = push_valid && push_ready && !bypass;
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    mem_count_d = mem_count_q;
    pop_valid_d = pop_valid_q;
    pop_data_d  = pop_data_q;
    if (rd) begin
      pop_data_d  = mem_rdata;
      pop_valid_d = 1'b1;
      head_d      = head_q + PTR_ONE;
      mem_count_d = mem_count_q - CNT_ONE;
    end else if (bypass) begin
      pop_data_d  = push_data;
      pop_valid_d = 1'b1;
    end else if (pop_ready && pop_valid_q) begin
      pop_valid_d = 1'b0;
    end
    if (wr) begin
      tail_d      = tail_q + PTR_ONE;
      mem_count_d = mem_count_q + CNT_ONE;
    end
  end

  always_comb begin
    pop_valid = pop_valid_q;
    pop_data  = pop_data_q;
    level     = {1'b0, mem_count_q} + {{(ADDR_W+1){1'b0}}, pop_valid_q};
    mem_addr  = {{(DATA_W-ADDR_W){1'b0}}, (rd ? head_q : tail_q)};
    mem_we    = wr && !rst;
    mem_wdata = push_data;
  end

endmodule
